// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants and helpers shared by every VGA video source.
package vga_timing_pkg;
  localparam int POS_W = 10;
  localparam int MAX_TOTAL = 1 << POS_W;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;
  function automatic int h_total(input int vis, input int fp, input int sy, input int bp);
    return vis + fp + sy + bp;
  endfunction
  function automatic int v_total(input int vis, input int fp, input int sy, input int bp);
    return vis + fp + sy + bp;
  endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: N-stage 2-bit register delay line with a synchronous reset value.
module vga_sync_delay #(
  parameter int N = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_rst_val,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);
  if (N == 0) begin : g_bypass
    logic unused;
    assign unused = ^{i_clk, i_rst, i_rst_val};
    assign o_q = i_d;
  end else begin : g_pipe
    logic [N-1:0][1:0] stage_q, stage_d;
    always_comb begin
      stage_d[0] = i_d;
      for (int i = 1; i < N; i++) stage_d[i] = stage_q[i-1];
    end
    always_ff @(posedge i_clk) stage_q <= i_rst ? {N{i_rst_val}} : stage_d;
    assign o_q = stage_q[N-1];
  end
endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: raster position counters, visible/start decodes and delayed sync pulses.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   SYNC_DELAY  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [POS_W-1:0] o_hpos,
  output logic [POS_W-1:0] o_vpos,
  output logic             o_visible,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_hsync,
  output logic             o_vsync
);
  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed position counter range");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_generator: SYNC_DELAY must be 0..4");
  end
  logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic h_wrap, v_wrap, hs_raw, vs_raw;
  sync_t sync_raw, sync_dly;
  always_comb begin
    h_wrap = int'(hpos_q) == H_TOTAL - 1;
    v_wrap = int'(vpos_q) == V_TOTAL - 1;
    hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
    vpos_d = !h_wrap ? vpos_q : v_wrap ? '0 : vpos_q + 1'b1;
    hs_raw = int'(hpos_q) >= H_VISIBLE + H_FRONT && int'(hpos_q) < H_VISIBLE + H_FRONT + H_SYNC;
    vs_raw = int'(vpos_q) >= V_VISIBLE + V_FRONT && int'(vpos_q) < V_VISIBLE + V_FRONT + V_SYNC;
    sync_raw.hsync = hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_raw.vsync = vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end
  always_ff @(posedge i_clk) begin
    hpos_q <= i_rst ? '0 : hpos_d;
    vpos_q <= i_rst ? '0 : vpos_d;
  end
  // Delay line resets to the idle level so a reset never leaves a partial pulse behind.
  vga_sync_delay #(.N(SYNC_DELAY)) u_sync_delay (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rst_val ({2{~SYNC_ACTIVE}}),
    .i_d       (sync_raw),
    .o_q       (sync_dly)
  );
  assign o_hpos        = hpos_q;
  assign o_vpos        = vpos_q;
  assign o_visible     = int'(hpos_q) < H_VISIBLE && int'(vpos_q) < V_VISIBLE;
  assign o_line_start  = hpos_q == '0;
  assign o_frame_start = hpos_q == '0 && vpos_q == '0;
  assign o_hsync       = sync_dly.hsync;
  assign o_vsync       = sync_dly.vsync;
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: directed checks of default, short-frame and tiny raster configurations.
module tb_vga_timing_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic [9:0] h0, v0, h1, v1, h2, v2;
  logic vis0, ls0, fs0, hs0, vs0;
  logic vis1, ls1, fs1, hs1, vs1;
  logic vis2, ls2, fs2, hs2, vs2;
  int vectors = 0, miscompares = 0;

  vga_timing_generator u_dut0 (
    .i_clk(clk), .i_rst(rst0), .o_hpos(h0), .o_vpos(v0), .o_visible(vis0),
    .o_line_start(ls0), .o_frame_start(fs0), .o_hsync(hs0), .o_vsync(vs0)
  );
  vga_timing_generator #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .o_hpos(h1), .o_vpos(v1), .o_visible(vis1),
    .o_line_start(ls1), .o_frame_start(fs1), .o_hsync(hs1), .o_vsync(vs1)
  );
  vga_timing_generator #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .o_hpos(h2), .o_vpos(v2), .o_visible(vis2),
    .o_line_start(ls2), .o_frame_start(fs2), .o_hsync(hs2), .o_vsync(vs2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int ls_at[4], fs_at[4];
    int ls_n, fs_n, pos_err, vis_err, hs_err, vs_err, hs_low, vs_low, hs_first, vs_first, vs_last, vis_cnt, k, early;
    // Default raster: reset state, two lines
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    check("rst_hpos", h0, 0);
    check("rst_vpos", v0, 0);
    check("rst_visible", vis0, 1);
    check("rst_line_start", ls0, 1);
    check("rst_frame_start", fs0, 1);
    check("rst_hsync", hs0, 1);
    check("rst_vsync", vs0, 1);
    ls_n = 0; fs_n = 0; pos_err = 0; vis_err = 0; hs_err = 0; hs_low = 0; hs_first = -1;
    for (int n = 0; n < 1600; n++) begin
      if (ls0) begin
        if (ls_n < 4) ls_at[ls_n] = n;
        ls_n++;
      end
      if (fs0) fs_n++;
      if (int'(h0) != n % 800 || int'(v0) != n / 800) pos_err++;
      if (n < 800 && vis0 !== (n < 640)) vis_err++;
      if (hs0 !== !((n % 800) >= 657 && (n % 800) <= 752)) hs_err++;
      if (!hs0) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
      if (n == 799) begin
        check("wrap_pre_hpos", h0, 799);
        check("wrap_pre_vpos", v0, 0);
      end
      if (n == 800) begin
        check("wrap_hpos", h0, 0);
        check("wrap_vpos", v0, 1);
      end
      @(negedge clk);
    end
    check("line_start_count", ls_n, 2);
    check("line_start_first", ls_at[0], 0);
    check("line_start_period", ls_at[1] - ls_at[0], 800);
    check("frame_start_count_2lines", fs_n, 1);
    check("position_errors", pos_err, 0);
    check("visible_line0_errors", vis_err, 0);
    check("hsync_shape_errors", hs_err, 0);
    check("hsync_low_clocks", hs_low, 192);
    check("hsync_first_low", hs_first, 657);
    // Short-frame raster (8 lines of 800): frame timing
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    fs_n = 0; vs_low = 0; vs_first = -1; vs_last = -1; vis_cnt = 0;
    for (int n = 0; n <= 12800; n++) begin
      if (fs1) begin
        if (fs_n < 4) fs_at[fs_n] = n;
        fs_n++;
      end
      if (n < 6400) begin
        if (!vs1) begin
          vs_low++;
          if (vs_first < 0) vs_first = n;
          vs_last = n;
        end
        if (vis1) vis_cnt++;
      end
      @(negedge clk);
    end
    check("frame_start_count", fs_n, 3);
    check("frame_period_0", fs_at[1] - fs_at[0], 6400);
    check("frame_period_1", fs_at[2] - fs_at[1], 6400);
    check("vsync_low_clocks", vs_low, 1600);
    check("vsync_first_low", vs_first, 4001);
    check("vsync_last_low", vs_last, 5600);
    check("visible_per_frame", vis_cnt, 2560);
    // Mid-frame reset while both syncs are asserted
    k = 0;
    while (!(h1 == 10'd700 && v1 == 10'd5) && k < 8000) begin
      @(negedge clk);
      k++;
    end
    check("mid_reset_reached", (h1 == 10'd700 && v1 == 10'd5), 1);
    check("mid_pre_hsync", hs1, 0);
    check("mid_pre_vsync", vs1, 0);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    check("mid_rst_hpos", h1, 0);
    check("mid_rst_vpos", v1, 0);
    check("mid_rst_hsync", hs1, 1);
    check("mid_rst_vsync", vs1, 1);
    early = 0;
    for (int n = 0; n <= 657; n++) begin
      if (n < 657 && (!hs1 || !vs1)) early++;
      if (n == 657) begin
        check("mid_rst_hsync_return", hs1, 0);
        check("mid_rst_vsync_idle", vs1, 1);
      end
      @(negedge clk);
    end
    check("mid_rst_early_sync", early, 0);
    // Tiny raster 14x7, no sync delay
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    ls_n = 0; fs_n = 0; hs_err = 0; vs_err = 0; hs_low = 0; vs_low = 0;
    for (int n = 0; n <= 98; n++) begin
      if (ls2 && n < 98) begin
        if (ls_n < 4) ls_at[ls_n] = n;
        ls_n++;
      end
      if (fs2) begin
        if (fs_n < 4) fs_at[fs_n] = n;
        fs_n++;
      end
      if (n < 98) begin
        if (hs2 !== !((n % 14) >= 10 && (n % 14) <= 11)) hs_err++;
        if (vs2 !== !((n / 14) == 5)) vs_err++;
        if (!hs2) hs_low++;
        if (!vs2) vs_low++;
      end
      if (n == 97) begin
        check("small_wrap_pre_hpos", h2, 13);
        check("small_wrap_pre_vpos", v2, 6);
      end
      if (n == 98) begin
        check("small_wrap_hpos", h2, 0);
        check("small_wrap_vpos", v2, 0);
      end
      @(negedge clk);
    end
    check("small_lines_per_frame", ls_n, 7);
    check("small_h_total", ls_at[1] - ls_at[0], 14);
    check("small_frame_count", fs_n, 2);
    check("small_frame_period", fs_at[1] - fs_at[0], 98);
    check("small_hsync_errors", hs_err, 0);
    check("small_vsync_errors", vs_err, 0);
    check("small_hsync_low", hs_low, 14);
    check("small_vsync_low", vs_low, 14);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Produces the raster scan that drives all video sources in the VGA path: horizontal/vertical position counters, a visible-region flag, and HSYNC/VSYNC pulses. Its position and visible outputs feed the test pattern generator (and any other video source) directly. Sync outputs are delayed so they line up with the registered video those sources produce. The default is 640x480 @ 60 Hz on a 25 MHz pixel clock.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, HSYNC pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, VSYNC pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of o_hsync/o_vsync (0 = active-low)
SYNC_DELAY, 1, clocks of delay applied to sync outputs relative to position outputs (0..4)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  synchronous, active-high reset
o_hpos  out  10  horizontal position, 0..H_TOTAL-1
o_vpos  out  10  vertical position, 0..V_TOTAL-1
o_visible  out  1  high when o_hpos<H_VISIBLE and o_vpos<V_VISIBLE
o_line_start  out  1  one-clock pulse when o_hpos==0
o_frame_start  out  1  one-clock pulse when o_hpos==0 and o_vpos==0
o_hsync  out  1  horizontal sync, delayed SYNC_DELAY clocks
o_vsync  out  1  vertical sync, delayed SYNC_DELAY clocks

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be <=1024; violation is an elaboration error.
- Reset (i_rst high at a clock edge):
  - Next cycle: o_hpos=0, o_vpos=0, o_visible=1, o_line_start=1, o_frame_start=1.
  - Every stage of the sync delay line is loaded with the deasserted level (!SYNC_ACTIVE), so o_hsync=o_vsync=!SYNC_ACTIVE.
  - Reset mid-line or mid-frame behaves identically: no partial sync pulse survives.
- Horizontal counter:
  - Increments by 1 each clock.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Increments only on the clock where hpos wraps.
  - At V_TOTAL-1 it wraps to 0; this happens on the same clock as the hpos wrap, giving (799,524)->(0,0).
- o_visible, o_line_start and o_frame_start are combinational decodes of the registered counters. They are valid in the same cycle as the o_hpos/o_vpos they describe, so position-to-video latency is that of the downstream source.
- Raw sync, pre-delay:
  - hsync asserted for H_VISIBLE+H_FRONT <= hpos < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync asserted for V_VISIBLE+V_FRONT <= vpos < V_VISIBLE+V_FRONT+V_SYNC (490..491), for the whole of those lines.
- Delay line:
  - Raw hsync/vsync pass through a SYNC_DELAY-stage register delay line.
  - With SYNC_DELAY=0 the outputs are the raw decodes.
  - With the default of 1, the sync edges line up with the 1-clock registered video output of the pattern generator.
- No stall or enable input: the block free-runs whenever not in reset.

Decomposition:
- Shared package vga_timing_pkg holds the 640x480@60 constants (H_/V_ visible, porch and sync values), the position width (10), and H_TOTAL/V_TOTAL helper functions. The pattern generator and this block both import it.
- One sub-module, vga_sync_delay: a parameterised N-stage, 2-bit delay line with a synchronous reset value input. Counters and decodes stay in the top module.

Test Plan:
- Reset check: assert i_rst for 3 clocks, release. Required: first cycle shows hpos=0, vpos=0, visible=1, line_start=1, frame_start=1, hsync=vsync=1 (active-low idle).
- Line timing: run 2 lines. Required:
  - line_start pulses exactly 800 clocks apart.
  - visible is high for hpos 0..639 and low for 640..799 on line 0.
  - hpos sequence 799->0 coincides with vpos incrementing.
- HSYNC alignment: with SYNC_DELAY=1, o_hsync is low on the clocks after hpos=656..751. That is 96 clocks, starting one clock after hpos==656.
- Frame timing: run 2 full frames. Required:
  - frame_start pulses exactly 420000 clocks apart.
  - vsync is low for exactly 1600 clocks, on lines 490..491 shifted by 1 clock.
  - visible count per frame is 307200.
- Mid-frame reset: pulse i_rst at hpos=700, vpos=490, while both syncs are asserted. Required next cycle: hpos=0, vpos=0, hsync=vsync=1, and no sync reassertion until hpos 656 of line 0.
- Small config: H=8/2/2/2, V=4/1/1/1, SYNC_DELAY=0. Required:
  - H_TOTAL=14, V_TOTAL=7.
  - hsync is low during hpos 10..11 and vsync is low during vpos 5, with no delay.
  - wrap (13,6)->(0,0).
